// File: rtl/stat_px_pack.sv
// Packs the serial static-pixel stream into DATA_W-bit framebuffer words,
// LSB first, and writes them to consecutive addresses from 0 with a stallable
// write handshake until PX_TOTAL pixels are stored.
module stat_px_pack #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 14,
  parameter int unsigned PX_TOTAL = 168192
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              px_valid_i,
  input  logic              px_in_i,
  output logic              px_ready_o,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [DATA_W-1:0] wr_data_o,
  input  logic              wr_ready_i,
  output logic              done_o
);

  localparam int unsigned BitW  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int unsigned PxW   = $clog2(PX_TOTAL + 1);
  localparam int unsigned Words = (PX_TOTAL + DATA_W - 1) / DATA_W;

  localparam logic [BitW-1:0]   BitLast  = BitW'(DATA_W - 1);
  localparam logic [PxW-1:0]    PxLast   = PxW'(PX_TOTAL - 1);
  localparam logic [ADDR_W-1:0] AddrLast = ADDR_W'(Words - 1);

  typedef enum logic {StFill, StDone} state_e;

  state_e            state_q, state_d;
  logic [BitW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [PxW-1:0]    px_cnt_q, px_cnt_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic              wr_en_q, wr_en_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;

  logic              closing_next;
  logic              px_acc;
  logic              wr_acc;
  logic [DATA_W-1:0] new_word;

  // Handshake decode; px_ready depends on registered state only.
  always_comb begin
    closing_next = (bit_cnt_q == BitLast) || (px_cnt_q == PxLast);
    px_ready_o   = (state_q == StFill) && !(closing_next && wr_en_q);
    px_acc       = px_valid_i && px_ready_o;
    wr_acc       = wr_en_q && wr_ready_i;
    // sh is cleared on every close, so bits above bit_cnt are already zero.
    new_word            = sh_q;
    new_word[bit_cnt_q] = px_in_i;
  end

  // Next-state: flush wins over both handshakes.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    px_cnt_d  = px_cnt_q;
    sh_d      = sh_q;
    wr_en_d   = wr_en_q;
    wr_data_d = wr_data_q;
    wr_addr_d = wr_addr_q;
    if (flush_i) begin
      state_d   = StFill;
      bit_cnt_d = '0;
      px_cnt_d  = '0;
      sh_d      = '0;
      wr_en_d   = 1'b0;
      wr_data_d = '0;
      wr_addr_d = '0;
    end else begin
      if (wr_acc) begin
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q + ADDR_W'(1);
        if (wr_addr_q == AddrLast) begin
          state_d = StDone;
        end
      end
      // A closing pixel is only accepted with no write pending, so it never
      // collides with wr_acc above.
      if (px_acc) begin
        px_cnt_d = (px_cnt_q == PxLast) ? '0 : px_cnt_q + PxW'(1);
        if (closing_next) begin
          wr_data_d = new_word;
          wr_en_d   = 1'b1;
          bit_cnt_d = '0;
          sh_d      = '0;
        end else begin
          sh_d      = new_word;
          bit_cnt_d = bit_cnt_q + BitW'(1);
        end
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StFill;
      bit_cnt_q <= '0;
      px_cnt_q  <= '0;
      sh_q      <= '0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
      wr_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      px_cnt_q  <= px_cnt_d;
      sh_q      <= sh_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      wr_addr_q <= wr_addr_d;
    end
  end

  assign wr_en_o   = wr_en_q;
  assign wr_data_o = wr_data_q;
  assign wr_addr_o = wr_addr_q;
  assign done_o    = (state_q == StDone);

endmodule

// File: tb/tb_stat_px_pack.sv
// Scoreboard bench for stat_px_pack on a 40-pixel frame of 16-bit words.
module tb_stat_px_pack;

  localparam int DW = 16;
  localparam int AW = 4;
  localparam int PT = 40;
  localparam int NW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          px_valid;
  logic          px_in;
  logic          px_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_ready;
  logic          done;

  stat_px_pack #(
    .DATA_W  (DW),
    .ADDR_W  (AW),
    .PX_TOTAL(PT)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush_i   (flush),
    .px_valid_i(px_valid),
    .px_in_i   (px_in),
    .px_ready_o(px_ready),
    .wr_en_o   (wr_en),
    .wr_addr_o (wr_addr),
    .wr_data_o (wr_data),
    .wr_ready_i(wr_ready),
    .done_o    (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t           exp_q[$];
  int            n_checks = 0;
  int            n_fail = 0;
  int            m_bit, m_px, m_idx, m_words;
  logic [DW-1:0] m_sh;
  logic [AW-1:0] m_addr;
  bit            m_done;
  bit            frame_bits[PT];
  int            valid_mode, ready_mode, stall_left;
  bit            stall_used;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_clear();
    m_bit = 0; m_px = 0; m_idx = 0; m_words = 0;
    m_sh = '0; m_addr = '0; m_done = 1'b0;
    exp_q.delete();
  endfunction

  function automatic bit exp_ready();
    return !m_done && !(((m_bit == DW - 1) || (m_px == PT - 1)) && (exp_q.size() != 0));
  endfunction

  function automatic void accept(input bit v);
    m_sh[m_bit] = v;
    m_idx++;
    if ((m_bit == DW - 1) || (m_px == PT - 1)) begin
      exp_q.push_back(wr_t'{addr: AW'(m_words), data: m_sh});
      m_words++;
      m_sh  = '0;
      m_bit = 0;
    end else begin
      m_bit++;
    end
    m_px = (m_px == PT - 1) ? 0 : m_px + 1;
  endfunction

  task automatic drive();
    px_valid = (valid_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
    px_in    = frame_bits[(m_idx < PT) ? m_idx : 0];
    if (ready_mode == 2 && !stall_used && exp_q.size() != 0) begin
      stall_left = 20;
      stall_used = 1'b1;
    end
    if (stall_left > 0) begin
      wr_ready = 1'b0;
      stall_left--;
    end else if (ready_mode == 0) wr_ready = 1'b0;
    else if (ready_mode == 1) wr_ready = 1'b1;
    else wr_ready = 1'($urandom_range(0, 1));
  endtask

  // One clock: compare at negedge, update model for the coming edge, drive after it.
  task automatic step();
    bit  rdy, pend;
    wr_t w;
    @(negedge clk);
    rdy  = exp_ready();
    pend = (exp_q.size() != 0);
    check("px_ready", px_ready, rdy);
    check("wr_en", wr_en, pend);
    check("wr_addr", wr_addr, m_addr);
    check("done", done, m_done);
    if (pend) check("wr_data", wr_data, exp_q[0].data);
    if (flush) begin
      model_clear();
    end else begin
      if (pend && wr_ready) begin
        w = exp_q.pop_front();
        m_addr++;
        if (w.addr == AW'(NW - 1)) m_done = 1'b1;
      end
      if (px_valid && rdy) accept(px_in);
    end
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic run_to_done(input int max_cycles);
    int n = 0;
    while (!m_done && n < max_cycles) begin
      step();
      n++;
    end
    check("frame_done", done, 1);
    check("final_addr", wr_addr, NW);
    check("ready_after_done", px_ready, 0);
    repeat (4) step();
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_wr_en", wr_en, 0);
    check("flush_addr", wr_addr, 0);
    check("flush_done", done, 0);
    check("flush_ready", px_ready, 1);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; flush = 1'b0; px_valid = 1'b0; px_in = 1'b0; wr_ready = 1'b0;
    valid_mode = 0; ready_mode = 1; stall_left = 0; stall_used = 1'b1;
    model_clear();
    #12;
    check("rst_px_ready", px_ready, 1);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // All ones: expect FFFF, FFFF, 00FF.
    for (int i = 0; i < PT; i++) frame_bits[i] = 1'b1;
    @(posedge clk); #1; drive();
    run_to_done(200);

    // Alternating 1,0,...: expect 5555, 5555, 0055.
    for (int i = 0; i < PT; i++) frame_bits[i] = (i % 2 == 0);
    do_flush();
    run_to_done(200);

    // Random stream, random valid/ready, one 20-cycle stall on the first write.
    for (int i = 0; i < PT; i++) frame_bits[i] = 1'($urandom_range(0, 1));
    valid_mode = 1; ready_mode = 2; stall_used = 1'b0;
    do_flush();
    run_to_done(2000);

    // Flush mid-frame with a write pending, then restream.
    for (int i = 0; i < PT; i++) frame_bits[i] = 1'($urandom_range(0, 1));
    valid_mode = 0; ready_mode = 0;
    do_flush();
    n = 0;
    while (!(m_idx >= 20 && exp_q.size() != 0) && n < 100) begin
      step();
      n++;
    end
    check("pending_before_flush", wr_en, 1);
    do_flush();
    ready_mode = 2;
    run_to_done(2000);

    // Asynchronous reset mid-word at bit 7, then a clean frame.
    ready_mode = 1;
    do_flush();
    n = 0;
    while (m_bit != 7 && n < 50) begin
      step();
      n++;
    end
    check("bit7_reached", m_bit, 7);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_px_ready", px_ready, 1);
    check("arst_wr_en", wr_en, 0);
    check("arst_wr_addr", wr_addr, 0);
    check("arst_wr_data", wr_data, 0);
    check("arst_done", done, 0);
    px_valid = 1'b0;
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1; drive();
    run_to_done(200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
